// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron fed by a synapse spike level.
// Optional leak is enabled by defining LIF_LEAK_EN.
module lif_neuron #(
  parameter int WIDTH       = 8,
  parameter int WEIGHT      = 64,
  parameter int THRESHOLD   = 192,
  parameter int LEAK_SHIFT  = 2,
  parameter int LEAK_PERIOD = 4,
  parameter int REFRACTORY  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             spike_in,
  output logic             spike_out,
  output logic [WIDTH-1:0] membrane,
  output logic             refractory
);

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    FIRE      = 2'd1,
    REFRACT   = 2'd2
  } state_t;

  localparam int RW =
    (REFRACTORY < 2) ? 1 : $clog2(REFRACTORY + 1);
  localparam logic [WIDTH-1:0] W    = WIDTH'(WEIGHT);
  localparam logic [WIDTH-1:0] TH   = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] MAXV = '1;

  state_t            state;
  state_t            state_n;
  logic [WIDTH-1:0]  mem_n;
  logic [RW-1:0]     refr_cnt;
  logic [RW-1:0]     refr_n;
  logic              spike_in_q;
  logic              ev;
  logic [WIDTH-1:0]  v1;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  v2;
  logic              fire_now;

  assign ev = spike_in & ~spike_in_q;

`ifdef LIF_LEAK_EN
  localparam int LW =
    (LEAK_PERIOD < 2) ? 1 : $clog2(LEAK_PERIOD);

  logic [LW-1:0]    leak_cnt;
  logic             tick;
  logic [WIDTH-1:0] leak_amt;

  assign tick = (leak_cnt == LW'(LEAK_PERIOD - 1));

  // Leak is at least 1 so small potentials still decay to 0
  always_comb begin
    leak_amt = membrane >> LEAK_SHIFT;
    if (leak_amt == '0)
      leak_amt = WIDTH'(1);
    v1 = membrane;
    if (tick && membrane != '0)
      v1 = (membrane > leak_amt) ?
           (membrane - leak_amt) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      leak_cnt <= '0;
    else if (en) begin
      if (fire_now || state == FIRE)
        leak_cnt <= '0;
      else if (state == INTEGRATE)
        leak_cnt <= tick ? '0 : leak_cnt + LW'(1);
    end
  end
`else
  assign v1 = membrane;
`endif

  assign sum = {1'b0, v1} + (ev ? {1'b0, W} : '0);
  assign v2  = sum[WIDTH] ? MAXV : sum[WIDTH-1:0];
  assign fire_now = (state == INTEGRATE) && (v2 >= TH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INTEGRATE;
      membrane   <= '0;
      refr_cnt   <= '0;
      spike_in_q <= 1'b0;
    end else begin
      state      <= state_n;
      membrane   <= mem_n;
      refr_cnt   <= refr_n;
      spike_in_q <= spike_in;
    end
  end

  always_comb begin
    state_n = state;
    mem_n   = membrane;
    refr_n  = refr_cnt;
    if (en) begin
      case (state)
        INTEGRATE: begin
          if (fire_now) begin
            mem_n   = '0;
            state_n = FIRE;
          end else begin
            mem_n = v2;
          end
        end
        FIRE: begin
          mem_n = '0;
          if (REFRACTORY == 0) begin
            state_n = INTEGRATE;
          end else begin
            state_n = REFRACT;
            refr_n  = RW'(REFRACTORY);
          end
        end
        REFRACT: begin
          mem_n = '0;
          if (refr_cnt <= RW'(1)) begin
            state_n = INTEGRATE;
            refr_n  = '0;
          end else begin
            refr_n = refr_cnt - RW'(1);
          end
        end
        default: begin
          state_n = INTEGRATE;
          mem_n   = '0;
          refr_n  = '0;
        end
      endcase
    end
  end

  assign spike_out  = (state == FIRE);
  assign refractory = (state == REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default instance plus a
// saturating instance (WEIGHT=200, THRESHOLD=255).
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       spike_in;
  logic       spike_out;
  logic [7:0] membrane;
  logic       refractory;
  logic       sin5;
  logic       so5;
  logic [7:0] mem5;
  logic       rf5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lif_neuron u1 (
    .clk(clk), .reset(reset), .en(en),
    .spike_in(spike_in), .spike_out(spike_out),
    .membrane(membrane), .refractory(refractory)
  );

  lif_neuron #(.WEIGHT(200), .THRESHOLD(255)) u5 (
    .clk(clk), .reset(reset), .en(en),
    .spike_in(sin5), .spike_out(so5),
    .membrane(mem5), .refractory(rf5)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic step5(input logic s,
                       input logic [7:0] m,
                       input logic so,
                       input logic rf,
                       input string nm);
    @(negedge clk);
    sin5 = s;
    @(posedge clk);
    #1;
    chk({nm, " mem5"}, 32'(mem5), 32'(m));
    chk({nm, " so5"}, 32'(so5), 32'(so));
    chk({nm, " rf5"}, 32'(rf5), 32'(rf));
  endtask

`ifndef LIF_LEAK_EN
  typedef struct {
    logic       rst;
    logic       en;
    logic       s;
    logic [7:0] mem;
    logic       so;
    logic       rf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e,
                     input logic s, input int m,
                     input logic so, input logic rf);
    vec_t v;
    v.rst = r; v.en = e; v.s = s;
    v.mem = 8'(m); v.so = so; v.rf = rf;
    tbl.push_back(v);
  endtask

  task automatic fill();
    // three separated events -> fire, 3 refractory cycles
    add(0,1,1, 64,0,0); add(0,1,0, 64,0,0);
    add(0,1,0, 64,0,0); add(0,1,1,128,0,0);
    add(0,1,0,128,0,0); add(0,1,1,  0,1,0);
    add(0,1,0,  0,0,1); add(0,1,0,  0,0,1);
    add(0,1,0,  0,0,1); add(0,1,0,  0,0,0);
    // events in REFRACT and on its exit edge are dropped
    add(0,1,1, 64,0,0); add(0,1,0, 64,0,0);
    add(0,1,1,128,0,0); add(0,1,0,128,0,0);
    add(0,1,1,  0,1,0); add(0,1,0,  0,0,1);
    add(0,1,1,  0,0,1); add(0,1,0,  0,0,1);
    add(0,1,1,  0,0,0); add(0,1,0,  0,0,0);
    add(0,1,1, 64,0,0); add(0,1,0, 64,0,0);
    // held-high input is a single event
    add(1,1,0,  0,0,0);
    for (int i = 0; i < 20; i++)
      add(0,1,1, 64,0,0);
    add(0,1,0, 64,0,0); add(0,1,1,128,0,0);
    add(0,1,0,128,0,0);
    // en=0 freezes and drops edges
    add(0,0,1,128,0,0); add(0,0,0,128,0,0);
    add(0,0,1,128,0,0); add(0,1,1,128,0,0);
    add(0,1,0,128,0,0); add(0,1,1,  0,1,0);
    add(0,1,0,  0,0,1); add(0,0,0,  0,0,1);
    add(0,1,0,  0,0,1); add(0,1,0,  0,0,1);
    add(0,1,0,  0,0,0); add(0,1,1, 64,0,0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0;
    spike_in = 1'b0; sin5 = 1'b0;
    #1;
    chk("rst mem", 32'(membrane), 32'd0);
    chk("rst so", 32'(spike_out), 32'd0);
    chk("rst rf", 32'(refractory), 32'd0);
    repeat (2) @(posedge clk);

`ifndef LIF_LEAK_EN
    @(negedge clk);
    reset = 1'b0; en = 1'b1;
    fill();
    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      en = tbl[i].en;
      spike_in = tbl[i].s;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem", i),
          32'(membrane), 32'(tbl[i].mem));
      chk($sformatf("v%0d so", i),
          32'(spike_out), 32'(tbl[i].so));
      chk($sformatf("v%0d rf", i),
          32'(refractory), 32'(tbl[i].rf));
    end
`else
    begin
      int e = 0;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        reset = 1'b0; en = 1'b1;
        spike_in = (k == 0);
        @(posedge clk);
        #1;
        if (k == 0)
          e = 64;
        else if (k % 4 == 3 && e > 0)
          e = e - (((e >> 2) > 0) ? (e >> 2) : 1);
        chk($sformatf("leak k%0d", k),
            32'(membrane), 32'(e));
        if (k == 3)  chk("leak 48", 32'(membrane), 32'd48);
        if (k == 7)  chk("leak 36", 32'(membrane), 32'd36);
        if (k == 11) chk("leak 27", 32'(membrane), 32'd27);
        if (k == 15) chk("leak 21", 32'(membrane), 32'd21);
      end
      chk("leak floor", 32'(membrane), 32'd0);
    end
`endif

    // saturating instance, then reset mid-REFRACT
    @(negedge clk);
    reset = 1'b1; spike_in = 1'b0; en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step5(1, 200, 0, 0, "sat e1");
    step5(0, 200, 0, 0, "sat idle");
    step5(1,   0, 1, 0, "sat fire");
    step5(0,   0, 0, 1, "sat refr");
    #2;
    reset = 1'b1;
    #1;
    chk("midrst so5", 32'(so5), 32'd0);
    chk("midrst rf5", 32'(rf5), 32'd0);
    chk("midrst mem5", 32'(mem5), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step5(0,   0, 0, 0, "post rst");
    step5(1, 200, 0, 0, "post ev");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
